// File: rtl/vga_timing_gen.sv
// Runtime-reconfigurable VGA timing generator: pixel divider, h/v counters, registered sync/de/strobes.
// Define VGA_TIMING_FRAME_CNT_EN to add a 16-bit frame counter output (frame_cnt).
module vga_timing_gen #(
  parameter int H_BITS     = 12,
  parameter int V_BITS     = 11,
  parameter int PERIOD     = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [H_BITS-1:0] cfg_h_active,
  input  logic [H_BITS-1:0] cfg_h_fp,
  input  logic [H_BITS-1:0] cfg_h_sync,
  input  logic [H_BITS-1:0] cfg_h_bp,
  input  logic [V_BITS-1:0] cfg_v_active,
  input  logic [V_BITS-1:0] cfg_v_fp,
  input  logic [V_BITS-1:0] cfg_v_sync,
  input  logic [V_BITS-1:0] cfg_v_bp,
  output logic              cfg_err,
  output logic              pixel_tick,
  output logic [H_BITS-1:0] hcnt,
  output logic [V_BITS-1:0] vcnt,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              line_start,
  output logic              frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  localparam int HW      = H_BITS + 2;
  localparam int VW      = V_BITS + 2;
  localparam int DW      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int H_TOT_P = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT_P = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [DW-1:0] DIV_MAX = DW'(PERIOD - 1);

  logic [DW-1:0]     div;
  logic [H_BITS-1:0] ha, hf, hs, hb, pha, phf, phs, phb;
  logic [V_BITS-1:0] va, vf, vs, vb, pva, pvf, pvs, pvb;

  logic              tick, h_wrap, v_wrap, frame_wrap, load, accept, cfg_bad;
  logic [HW-1:0]     h_total, c_htot, hs_beg, hs_end;
  logic [VW-1:0]     v_total, c_vtot, vs_beg, vs_end;
  logic [H_BITS-1:0] h_nxt, n_ha, n_hf, n_hs;
  logic [V_BITS-1:0] v_nxt, n_va, n_vf, n_vs;
  logic              hs_on, vs_on, de_nxt;

  always_comb begin
    tick       = enable && (div == '0);
    h_total    = HW'(ha) + HW'(hf) + HW'(hs) + HW'(hb);
    v_total    = VW'(va) + VW'(vf) + VW'(vs) + VW'(vb);
    h_wrap     = (HW'(hcnt) == h_total - 1'b1);
    v_wrap     = (VW'(vcnt) == v_total - 1'b1);
    frame_wrap = h_wrap && v_wrap;
    h_nxt      = h_wrap ? '0 : hcnt + 1'b1;
    v_nxt      = h_wrap ? (v_wrap ? '0 : vcnt + 1'b1) : vcnt;
    // A pending set is outstanding whenever cfg_ready is low; it takes effect for pixel (0,0) itself.
    load       = tick && frame_wrap && !cfg_ready;
    n_ha       = load ? pha : ha;
    n_hf       = load ? phf : hf;
    n_hs       = load ? phs : hs;
    n_va       = load ? pva : va;
    n_vf       = load ? pvf : vf;
    n_vs       = load ? pvs : vs;
    hs_beg     = HW'(n_ha) + HW'(n_hf);
    hs_end     = hs_beg + HW'(n_hs);
    vs_beg     = VW'(n_va) + VW'(n_vf);
    vs_end     = vs_beg + VW'(n_vs);
    hs_on      = (HW'(h_nxt) >= hs_beg) && (HW'(h_nxt) < hs_end);
    vs_on      = (VW'(v_nxt) >= vs_beg) && (VW'(v_nxt) < vs_end);
    de_nxt     = (h_nxt < n_ha) && (v_nxt < n_va);
  end

  always_comb begin
    accept  = cfg_valid && cfg_ready;
    c_htot  = HW'(cfg_h_active) + HW'(cfg_h_fp) + HW'(cfg_h_sync) + HW'(cfg_h_bp);
    c_vtot  = VW'(cfg_v_active) + VW'(cfg_v_fp) + VW'(cfg_v_sync) + VW'(cfg_v_bp);
    cfg_bad = (cfg_h_active == '0) || (cfg_h_sync == '0) ||
              (cfg_v_active == '0) || (cfg_v_sync == '0) ||
              (c_htot == '0) || (c_vtot == '0) ||
              (c_htot > (HW'(1) << H_BITS)) || (c_vtot > (VW'(1) << V_BITS));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div         <= DIV_MAX;
      ha          <= H_BITS'(H_ACTIVE);
      hf          <= H_BITS'(H_FP);
      hs          <= H_BITS'(H_SYNC);
      hb          <= H_BITS'(H_BP);
      va          <= V_BITS'(V_ACTIVE);
      vf          <= V_BITS'(V_FP);
      vs          <= V_BITS'(V_SYNC);
      vb          <= V_BITS'(V_BP);
      {pha, phf, phs, phb} <= '0;
      {pva, pvf, pvs, pvb} <= '0;
      hcnt        <= H_BITS'(H_TOT_P - 1);
      vcnt        <= V_BITS'(V_TOT_P - 1);
      hsync       <= ~H_SYNC_POL;
      vsync       <= ~V_SYNC_POL;
      de          <= 1'b0;
      pixel_tick  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      cfg_err     <= 1'b0;
      cfg_ready   <= 1'b1;
    end else begin
      pixel_tick  <= tick;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      cfg_err     <= 1'b0;
      if (enable) div <= (div == '0) ? DIV_MAX : div - 1'b1;
      if (tick) begin
        hcnt        <= h_nxt;
        vcnt        <= v_nxt;
        hsync       <= hs_on ? H_SYNC_POL : ~H_SYNC_POL;
        vsync       <= vs_on ? V_SYNC_POL : ~V_SYNC_POL;
        de          <= de_nxt;
        line_start  <= h_wrap;
        frame_start <= frame_wrap;
      end
      if (load) begin
        {ha, hf, hs, hb} <= {pha, phf, phs, phb};
        {va, vf, vs, vb} <= {pva, pvf, pvs, pvb};
        cfg_ready        <= 1'b1;
      end else if (accept) begin
        if (cfg_bad) begin
          cfg_err <= 1'b1;
        end else begin
          {pha, phf, phs, phb} <= {cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp};
          {pva, pvf, pvs, pvb} <= {cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp};
          cfg_ready            <= 1'b0;
        end
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Counts on the same edge that raises frame_start, so it reads 1 during the first frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) frame_cnt <= '0;
    else if (tick && frame_wrap) frame_cnt <= frame_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a small 15x8 timing (8/2/3/2 x 4/1/2/1), PERIOD=2.
module tb_vga_timing_gen;
  localparam int HB = 5;
  localparam int VB = 4;

  logic          clk, reset, enable, cfg_valid, cfg_ready, cfg_err;
  logic [HB-1:0] cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp, hcnt;
  logic [VB-1:0] cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp, vcnt;
  logic          pixel_tick, hsync, vsync, de, line_start, frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int rdy_c1;

  vga_timing_gen #(
    .H_BITS(HB), .V_BITS(VB), .PERIOD(2),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
    .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
    .cfg_err(cfg_err), .pixel_tick(pixel_tick), .hcnt(hcnt), .vcnt(vcnt),
    .hsync(hsync), .vsync(vsync), .de(de), .line_start(line_start), .frame_start(frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int ha, hf, hs, hb, va, vf, vs, vb);
    cfg_h_active = HB'(ha); cfg_h_fp = HB'(hf); cfg_h_sync = HB'(hs); cfg_h_bp = HB'(hb);
    cfg_v_active = VB'(va); cfg_v_fp = VB'(vf); cfg_v_sync = VB'(vs); cfg_v_bp = VB'(vb);
  endtask

  task automatic wait_frame_start(input string tag, input int max_clks);
    bit found = 0;
    for (int i = 0; i < max_clks && !found; i++) begin
      step();
      if (frame_start) found = 1;
    end
    chk({tag, "_found"}, int'(found), 1);
  endtask

  // Starts on a frame_start sample and walks exactly one frame worth of clocks.
  task automatic measure_frame(input string tag, input int clks, input int de_px, input int hs_px,
                               input int vs_px, input int lines, input int hs_lo, input int hs_hi);
    int n_de = 0, n_hs = 0, n_vs = 0, n_ls = 0, n_fs = 0, lo = 999, hi = -1;
    for (int c = 0; c < clks; c++) begin
      if (pixel_tick) begin
        if (de) n_de++;
        if (!vsync) n_vs++;
        if (line_start) n_ls++;
        if (frame_start) n_fs++;
        if (!hsync) begin
          n_hs++;
          if (int'(hcnt) < lo) lo = int'(hcnt);
          if (int'(hcnt) > hi) hi = int'(hcnt);
        end
      end
      step();
      if (c == 0) rdy_c1 = int'(cfg_ready);
    end
    chk({tag, "_de_px"}, n_de, de_px);
    chk({tag, "_hs_px"}, n_hs, hs_px);
    chk({tag, "_vs_px"}, n_vs, vs_px);
    chk({tag, "_lines"}, n_ls, lines);
    chk({tag, "_fs_once"}, n_fs, 1);
    chk({tag, "_hs_lo"}, lo, hs_lo);
    chk({tag, "_hs_hi"}, hi, hs_hi);
    chk({tag, "_next_fs"}, int'(frame_start), 1);
    chk({tag, "_next_h"}, int'(hcnt), 0);
    chk({tag, "_next_v"}, int'(vcnt), 0);
  endtask

  initial begin
    int moved, ticks, viol;
    bit hit;
    reset = 1'b1; enable = 1'b1; cfg_valid = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("rst_h", int'(hcnt), 14);
    chk("rst_v", int'(vcnt), 7);
    chk("rst_de", int'(de), 0);
    chk("rst_hs", int'(hsync), 1);
    chk("rst_vs", int'(vsync), 1);
    chk("rst_tick", int'(pixel_tick), 0);
    chk("rst_fs", int'(frame_start), 0);
    chk("rst_ls", int'(line_start), 0);
    chk("rst_rdy", int'(cfg_ready), 1);
    chk("rst_err", int'(cfg_err), 0);
    step(); step();
    reset = 1'b1;

    // First enabled clock only drains the divider.
    step();
    chk("rel_tick0", int'(pixel_tick), 0);
    chk("rel_h0", int'(hcnt), 14);
    step();
    chk("rel_tick1", int'(pixel_tick), 1);
    chk("rel_h1", int'(hcnt), 0);
    chk("rel_v1", int'(vcnt), 0);
    chk("rel_de", int'(de), 1);
    chk("rel_fs", int'(frame_start), 1);
    chk("rel_ls", int'(line_start), 1);

    measure_frame("def", 240, 32, 24, 30, 8, 10, 12);

    // Freeze mid-line.
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      step();
      if (pixel_tick && hcnt == 5) hit = 1;
    end
    chk("frz_found", int'(hit), 1);
    enable = 1'b0;
    moved = 0; ticks = 0;
    repeat (20) begin
      step();
      if (pixel_tick) ticks++;
      if (hcnt != 5 || vcnt != 0) moved++;
    end
    chk("frz_ticks", ticks, 0);
    chk("frz_moved", moved, 0);
    enable = 1'b1;
    step();
    chk("frz_res_tick0", int'(pixel_tick), 0);
    step();
    chk("frz_res_tick1", int'(pixel_tick), 1);
    chk("frz_res_h", int'(hcnt), 6);
    chk("frz_res_v", int'(vcnt), 0);

    // Rejects: zero h_sync, then h_total of 33 in a 5-bit field space.
    set_cfg(8, 2, 0, 2, 4, 1, 2, 1);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("rej0_err", int'(cfg_err), 1);
    chk("rej0_rdy", int'(cfg_ready), 1);
    step();
    chk("rej0_err_off", int'(cfg_err), 0);
    set_cfg(16, 8, 8, 1, 4, 1, 2, 1);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("rej1_err", int'(cfg_err), 1);
    chk("rej1_rdy", int'(cfg_ready), 1);
    wait_frame_start("rej_wait", 300);
    measure_frame("rej", 240, 32, 24, 30, 8, 10, 12);

    // Accept 10/1/2/0 x 3/1/1/0 mid-frame; sync ends exactly at total.
    repeat (50) step();
    set_cfg(10, 1, 2, 0, 3, 1, 1, 0);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("acc_rdy", int'(cfg_ready), 0);
    chk("acc_err", int'(cfg_err), 0);
    hit = 0; viol = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      step();
      if (frame_start) hit = 1;
      else if (cfg_ready) viol++;
    end
    chk("acc_found", int'(hit), 1);
    chk("acc_rdy_held", viol, 0);
    chk("acc_fs_de", int'(de), 1);
    measure_frame("new", 130, 30, 10, 13, 5, 11, 12);
    chk("acc_rdy_back", rdy_c1, 1);

    // Reset with a pending set discards it.
    repeat (20) step();
    set_cfg(12, 1, 1, 1, 3, 1, 1, 1);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("pend_rdy", int'(cfg_ready), 0);
    #3 reset = 1'b0;
    #1;
    chk("arst_h", int'(hcnt), 14);
    chk("arst_v", int'(vcnt), 7);
    chk("arst_rdy", int'(cfg_ready), 1);
    chk("arst_de", int'(de), 0);
    chk("arst_hs", int'(hsync), 1);
    chk("arst_tick", int'(pixel_tick), 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("arst_fcnt", int'(frame_cnt), 0);
`endif
    #2 reset = 1'b1;
    wait_frame_start("arst_wait", 4);
    measure_frame("post", 240, 32, 24, 30, 8, 10, 12);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("post_fcnt", int'(frame_cnt), 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end
endmodule
